// File: rtl/divisor_frequencia_param.sv
// Parametrised frequency divider for the toy's sequence timing.
// A prescaler counts up to a run-time reloadable limit and emits a one-cycle tick.
// Each tick toggles a square-wave output and advances an up/down step counter.
// The step counter either wraps or saturates at its terminal value.
// Everything runs on clock_entrada, and every output is registered.

module divisor_frequencia_param #(
    parameter int unsigned DIV_WIDTH   = 26,
    parameter int unsigned DIV_DEFAULT = 33554431,
    parameter int unsigned CONT_WIDTH  = 3
) (
    input  logic                  clock_entrada,
    input  logic                  botao,
    input  logic                  habilitar,
    input  logic [DIV_WIDTH-1:0]  divisor,
    input  logic                  carregar_divisor,
    input  logic                  direcao,
    input  logic                  modo_saturar,
    output logic                  pulso,
    output logic                  clock_saida,
    output logic [CONT_WIDTH-1:0] contador,
    output logic                  fim
);

    localparam logic [DIV_WIDTH-1:0]  LimReset = DIV_WIDTH'(DIV_DEFAULT);
    localparam logic [CONT_WIDTH-1:0] ContMax  = '1;

    logic [DIV_WIDTH-1:0]  pre_q, pre_d;
    logic [DIV_WIDTH-1:0]  lim_ativo_q, lim_ativo_d;
    logic [DIV_WIDTH-1:0]  lim_sombra_q, lim_sombra_d;
    logic                  pulso_q, pulso_d;
    logic                  clock_saida_q, clock_saida_d;
    logic [CONT_WIDTH-1:0] contador_q, contador_d;
    logic                  fim_q, fim_d;
    logic                  tick;

    // The prescaler has reached the active limit while enabled.
    assign tick = habilitar && (pre_q == lim_ativo_q);

    // Prescaler and limit bookkeeping.
    always_comb begin
        pre_d        = pre_q;
        lim_ativo_d  = lim_ativo_q;
        lim_sombra_d = lim_sombra_q;

        // The shadow limit loads even while the prescaler is frozen.
        if (carregar_divisor) begin
            lim_sombra_d = divisor;
        end

        if (tick) begin
            pre_d = '0;
            // A strobe on the tick edge bypasses the shadow so the newest value wins.
            lim_ativo_d = carregar_divisor ? divisor : lim_sombra_q;
        end else if (habilitar) begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Tick-driven outputs: pulse, square wave, step counter and terminal-count pulse.
    always_comb begin
        pulso_d       = tick;
        clock_saida_d = clock_saida_q ^ tick;
        contador_d    = contador_q;
        fim_d         = 1'b0;

        if (tick) begin
            if (direcao) begin
                if (contador_q != ContMax) begin
                    contador_d = contador_q + 1'b1;
                    // Entering saturation reports the terminal count once.
                    fim_d      = modo_saturar && (contador_d == ContMax);
                end else if (!modo_saturar) begin
                    contador_d = '0;
                    fim_d      = 1'b1;
                end
            end else begin
                if (contador_q != '0) begin
                    contador_d = contador_q - 1'b1;
                    fim_d      = modo_saturar && (contador_d == '0);
                end else if (!modo_saturar) begin
                    contador_d = ContMax;
                    fim_d      = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset; reset also drops any pending shadow limit.
    always_ff @(posedge clock_entrada) begin
        if (botao) begin
            pre_q         <= '0;
            lim_ativo_q   <= LimReset;
            lim_sombra_q  <= LimReset;
            pulso_q       <= 1'b0;
            clock_saida_q <= 1'b0;
            contador_q    <= '0;
            fim_q         <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            lim_ativo_q   <= lim_ativo_d;
            lim_sombra_q  <= lim_sombra_d;
            pulso_q       <= pulso_d;
            clock_saida_q <= clock_saida_d;
            contador_q    <= contador_d;
            fim_q         <= fim_d;
        end
    end

    assign pulso       = pulso_q;
    assign clock_saida = clock_saida_q;
    assign contador    = contador_q;
    assign fim         = fim_q;

endmodule

// File: tb/tb_divisor_frequencia_param.sv
// Directed bench for divisor_frequencia_param with a small prescaler (limit 3, 4-bit).
// Edge numbers in the comments count rising edges after reset is released.

module tb_divisor_frequencia_param;

    logic       clk;
    logic       botao;
    logic       habilitar;
    logic [3:0] divisor;
    logic       carregar_divisor;
    logic       direcao;
    logic       modo_saturar;
    logic       pulso;
    logic       clock_saida;
    logic [2:0] contador;
    logic       fim;

    int tests = 0;
    int fails = 0;

    divisor_frequencia_param #(
        .DIV_WIDTH   (4),
        .DIV_DEFAULT (3),
        .CONT_WIDTH  (3)
    ) dut (
        .clock_entrada    (clk),
        .botao            (botao),
        .habilitar        (habilitar),
        .divisor          (divisor),
        .carregar_divisor (carregar_divisor),
        .direcao          (direcao),
        .modo_saturar     (modo_saturar),
        .pulso            (pulso),
        .clock_saida      (clock_saida),
        .contador         (contador),
        .fim              (fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic p, input logic c,
                           input logic [2:0] n, input logic f);
        chk({tag, " pulso"}, {31'b0, pulso}, {31'b0, p});
        chk({tag, " clock_saida"}, {31'b0, clock_saida}, {31'b0, c});
        chk({tag, " contador"}, {29'b0, contador}, {29'b0, n});
        chk({tag, " fim"}, {31'b0, fim}, {31'b0, f});
    endtask

    initial begin
        botao            = 1'b1;
        habilitar        = 1'b0;
        divisor          = 4'd0;
        carregar_divisor = 1'b0;
        direcao          = 1'b1;
        modo_saturar     = 1'b0;

        // Reset
        step(1);
        chk_all("reset", 1'b0, 1'b0, 3'd0, 1'b0);
        botao     = 1'b0;
        habilitar = 1'b1;

        // Free run: tick every 4th edge, square wave period 8, wrap 7->0 at edge 32
        for (int k = 1; k <= 40; k++) begin
            step(1);
            chk_all($sformatf("run k=%0d", k), (k % 4) == 0, ((k / 4) % 2) == 1,
                    3'((k / 4) % 8), k == 32);
        end

        // Shadow load at pre=1: current period still ends at edge 44, then period 2
        step(1);                                  // edge 41, pre=1
        carregar_divisor = 1'b1;
        divisor          = 4'd1;
        step(1);                                  // edge 42
        carregar_divisor = 1'b0;
        chk("shadow e42 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk("shadow e43 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("shadow e44", 1'b1, 1'b1, 3'd3, 1'b0);
        step(1);
        chk("shadow e45 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("shadow e46", 1'b1, 1'b0, 3'd4, 1'b0);
        step(2);
        chk_all("shadow e48", 1'b1, 1'b1, 3'd5, 1'b0);

        // Load coincident with the tick at edge 50: period 3 starts immediately
        step(1);                                  // edge 49
        carregar_divisor = 1'b1;
        divisor          = 4'd2;
        step(1);                                  // edge 50
        carregar_divisor = 1'b0;
        chk_all("coinc e50", 1'b1, 1'b0, 3'd6, 1'b0);
        step(2);
        chk("coinc e52 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("coinc e53", 1'b1, 1'b1, 3'd7, 1'b0);
        step(3);
        chk_all("coinc e56 wrap", 1'b1, 1'b0, 3'd0, 1'b1);

        // Saturating down count from 2
        step(3);
        chk("sat e59 contador", {29'b0, contador}, 32'd1);
        step(3);
        chk("sat e62 contador", {29'b0, contador}, 32'd2);
        direcao      = 1'b0;
        modo_saturar = 1'b1;
        step(3);
        chk_all("sat e65", 1'b1, 1'b1, 3'd1, 1'b0);
        step(3);
        chk_all("sat e68 entry", 1'b1, 1'b0, 3'd0, 1'b1);
        step(1);
        chk_all("sat e69", 1'b0, 1'b0, 3'd0, 1'b0);
        step(2);
        chk_all("sat e71 hold", 1'b1, 1'b1, 3'd0, 1'b0);
        step(3);
        chk_all("sat e74 hold", 1'b1, 1'b0, 3'd0, 1'b0);
        direcao = 1'b1;
        step(3);
        chk_all("sat e77 up", 1'b1, 1'b1, 3'd1, 1'b0);
        step(3);
        chk_all("sat e80 up", 1'b1, 1'b0, 3'd2, 1'b0);
        modo_saturar = 1'b0;

        // Restore limit 3, then freeze at pre=2 while loading a shadow limit of 1
        carregar_divisor = 1'b1;
        divisor          = 4'd3;
        step(1);                                  // edge 81
        carregar_divisor = 1'b0;
        step(2);
        chk_all("lim3 e83", 1'b1, 1'b1, 3'd3, 1'b0);
        step(4);
        chk_all("lim3 e87", 1'b1, 1'b0, 3'd4, 1'b0);
        step(2);                                  // edge 89, pre=2
        habilitar        = 1'b0;
        carregar_divisor = 1'b1;
        divisor          = 4'd1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            carregar_divisor = 1'b0;
            chk_all($sformatf("freeze i=%0d", i), 1'b0, 1'b0, 3'd4, 1'b0);
        end
        habilitar = 1'b1;
        step(1);
        chk("resume e100 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("resume e101", 1'b1, 1'b1, 3'd5, 1'b0);
        step(1);
        chk("frzload e102 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("frzload e103", 1'b1, 1'b0, 3'd6, 1'b0);

        // Build state with clock_saida=1, contador=7 and a pending shadow, then reset
        carregar_divisor = 1'b1;
        divisor          = 4'd2;
        step(1);                                  // edge 104
        carregar_divisor = 1'b0;
        step(1);
        chk_all("prerst e105", 1'b1, 1'b1, 3'd7, 1'b0);
        carregar_divisor = 1'b1;
        divisor          = 4'd1;
        step(1);                                  // edge 106, shadow=1 pending
        carregar_divisor = 1'b0;
        botao            = 1'b1;
        step(1);
        chk_all("midrst e107", 1'b0, 1'b0, 3'd0, 1'b0);
        botao = 1'b0;
        step(3);
        chk("postrst e110 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("postrst e111", 1'b1, 1'b1, 3'd1, 1'b0);
        step(3);
        chk("postrst e114 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("postrst e115", 1'b1, 1'b0, 3'd2, 1'b0);

        // Limit 0: continuous pulso, clock_saida toggles and contador steps every edge
        carregar_divisor = 1'b1;
        divisor          = 4'd0;
        step(1);                                  // edge 116
        carregar_divisor = 1'b0;
        step(2);
        chk("lim0 e118 pulso", {31'b0, pulso}, 32'd0);
        step(1);
        chk_all("lim0 e119", 1'b1, 1'b1, 3'd3, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk_all($sformatf("lim0 k=%0d", k), 1'b1, ((1 + k) % 2) == 1,
                    3'((3 + k) % 8), k == 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
